// File: rtl/dec3t8_strobe.sv
// Registered 3-to-8 strobe decoder: accepts a code over valid/ready, holds the one-hot line
// for HOLD cycles, then GAP dead cycles. Define DEC3T8_ACTIVE_LOW_EN for active-low Y (74x138 style).
module dec3t8_strobe #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] A,
    input  logic       EN,
    output logic [7:0] Y,
    output logic       Busy,
    output logic       Idle
);

`ifdef DEC3T8_ACTIVE_LOW_EN
    localparam logic [7:0] INACT = 8'hFF;
`else
    localparam logic [7:0] INACT = 8'h00;
`endif

    // HOLD=0 is treated as 1 so every accept yields at least one strobe cycle
    localparam int         HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_EFF - 1);
    localparam logic [7:0] GAP_LD   = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam bit         HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_y;
    logic       r_busy;
    logic       r_idle;
    logic [7:0] w_line;

    // Flipping the selected bit of the inactive pattern serves both polarities
    assign w_line   = INACT ^ (8'h01 << A);
    assign in_ready = (r_state == S_IDLE) && EN && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_y     <= INACT;
            r_busy  <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_y     <= w_line;
                        r_cnt   <= HOLD_LD;
                        r_state <= S_DRIVE;
                        r_busy  <= 1'b1;
                        r_idle  <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (!EN) begin
                        r_y     <= INACT;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_idle  <= 1'b1;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == 8'd0) begin
                        r_y    <= INACT;
                        r_idle <= 1'b1;
                        if (HAS_GAP) begin
                            r_state <= S_GAP;
                            r_cnt   <= GAP_LD;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (!EN || r_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_y     <= INACT;
                    r_busy  <= 1'b0;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    assign Y    = r_y;
    assign Busy = r_busy;
    assign Idle = r_idle;

endmodule

// File: tb/tb_dec3t8_strobe.sv
// Scoreboard bench for dec3t8_strobe: dut0 HOLD=4/GAP=1, dut1 HOLD=1/GAP=0.
// Expected per-cycle outputs are queued with their due cycle and checked at negedge.
module tb_dec3t8_strobe;

`ifdef DEC3T8_ACTIVE_LOW_EN
    localparam logic [7:0] INACT = 8'hFF;
`else
    localparam logic [7:0] INACT = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, en0 = 1'b1, rdy0, busy0, idle0;
    logic [2:0] a0 = 3'd0;
    logic [7:0] y0;
    logic       v1 = 1'b0, en1 = 1'b1, rdy1, busy1, idle1;
    logic [2:0] a1 = 3'd0;
    logic [7:0] y1;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         due;
        int         dut;
        logic [7:0] y;
        logic       busy;
        logic       idle;
    } exp_t;

    exp_t exp_q[$];

    dec3t8_strobe #(.HOLD(4), .GAP(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .A(a0), .EN(en0),
        .Y(y0), .Busy(busy0), .Idle(idle0)
    );

    dec3t8_strobe #(.HOLD(1), .GAP(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .A(a1), .EN(en1),
        .Y(y1), .Busy(busy1), .Idle(idle1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] line(input int a);
        logic [7:0] v;
        v = 8'h01 << a;
        return INACT ^ v;
    endfunction

    task automatic push(input int dut, input int due, input logic [7:0] y,
                        input logic busy, input logic idle);
        exp_t e;
        e.due = due; e.dut = dut; e.y = y; e.busy = busy; e.idle = idle;
        exp_q.push_back(e);
    endtask

    // Full strobe for a code accepted at the edge following the current cycle
    task automatic exp_strobe(input int dut, input int a, input int hold, input int gap);
        for (int k = 1; k <= hold; k++) push(dut, cyc + k, line(a), 1'b1, 1'b0);
        for (int k = 1; k <= gap; k++) push(dut, cyc + hold + k, INACT, 1'b1, 1'b1);
        push(dut, cyc + hold + gap + 1, INACT, 1'b0, 1'b1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.due < cyc) chk($sformatf("late_d%0d@%0d", e.dut, e.due), cyc, e.due);
            else if (e.dut == 0) begin
                chk($sformatf("y0@%0d", cyc), y0, e.y);
                chk($sformatf("busy0@%0d", cyc), busy0, e.busy);
                chk($sformatf("idle0@%0d", cyc), idle0, e.idle);
            end else begin
                chk($sformatf("y1@%0d", cyc), y1, e.y);
                chk($sformatf("busy1@%0d", cyc), busy1, e.busy);
                chk($sformatf("idle1@%0d", cyc), idle1, e.idle);
            end
        end
    end

    initial begin
        // reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y", y0, INACT);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_idle", idle0, 1'b1);
        chk("rst_rdy", rdy0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_rdy0", rdy0, 1'b1);
        chk("rel_rdy1", rdy1, 1'b1);
        step(1);

        // single accept of A=5; A changes mid-strobe must be ignored
        v0 = 1'b1; a0 = 3'd5;
        #1 chk("t2_rdy", rdy0, 1'b1);
        exp_strobe(0, 5, 4, 1);
        step(1);
        v0 = 1'b0; a0 = 3'd2;
        #1 chk("t2_rdy_busy", rdy0, 1'b0);
        step(5);
        chk("t2_rdy_back", rdy0, 1'b1);

        // sweep with valid held high: accepts every 6 cycles
        v0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a0 = 3'(i);
            #1 chk($sformatf("t3_rdy%0d", i), rdy0, 1'b1);
            exp_strobe(0, i, 4, 1);
            step(6);
        end
        v0 = 1'b0;
        step(1);

        // EN dropped on 2nd drive cycle aborts without GAP
        a0 = 3'd3; v0 = 1'b1;
        push(0, cyc + 1, line(3), 1'b1, 1'b0);
        push(0, cyc + 2, line(3), 1'b1, 1'b0);
        push(0, cyc + 3, INACT, 1'b0, 1'b1);
        step(1);
        v0 = 1'b0;
        step(1);
        en0 = 1'b0;
        step(1);
        v0 = 1'b1; a0 = 3'd1;
        #1 chk("t4_rdy_en0", rdy0, 1'b0);
        push(0, cyc + 1, INACT, 1'b0, 1'b1);
        step(1);
        v0 = 1'b0; en0 = 1'b1;
        #1 chk("t4_rdy_en1", rdy0, 1'b1);
        step(1);

        // reset on 3rd drive cycle, then re-accept
        a0 = 3'd7; v0 = 1'b1;
        for (int k = 1; k <= 3; k++) push(0, cyc + k, line(7), 1'b1, 1'b0);
        push(0, cyc + 4, INACT, 1'b0, 1'b1);
        step(1);
        v0 = 1'b0;
        step(2);
        rst = 1'b1;
        #1 chk("t5_rdy_rst", rdy0, 1'b0);
        step(1);
        rst = 1'b0;
        v0 = 1'b1; a0 = 3'd4;
        #1 chk("t5_rdy_re", rdy0, 1'b1);
        exp_strobe(0, 4, 4, 1);
        step(1);
        v0 = 1'b0;
        step(6);

        // HOLD=1 GAP=0 back-to-back: one IDLE cycle between strobes
        v1 = 1'b1; a1 = 3'd2;
        exp_strobe(1, 2, 1, 0);
        step(1);
        a1 = 3'd6;
        #1 chk("t6_rdy_drive", rdy1, 1'b0);
        step(1);
        chk("t6_rdy_idle", rdy1, 1'b1);
        exp_strobe(1, 6, 1, 0);
        step(1);
        v1 = 1'b0;
        step(3);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1);
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
